// File: rtl/rgbw_tx_sched.sv
// rgbw_tx_sched
//   Output-side controller for the RGB->RGBW path. Pops 32-bit words from the
//   capture FIFO, converts GRB pixels to GRBW (optional white extraction) and
//   serialises the 32 result bits MSB first to the LED bit transmitter over a
//   valid/ready handshake. Stream-reset words produce a latch gap of
//   RESET_CLKS clocks, after which the per-frame pixel count is cleared.
//
// Parameters
//   RESET_CLKS  latch-gap length in clocks (>= 2)
//   EN_WHITE    1: W = min(G,R,B) subtracted from each colour; 0: W = 0
//   CNT_W       width of pixel_count
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   fifo_empty   input FIFO empty
//   fifo_rd      pop pulse; fifo_data valid on the following cycle
//   fifo_data    [31] valid, [30] stream_reset, [23:0] received bits (G,R,B,
//                bit 8n is the MSB of byte n)
//   tx_valid     bit offered to transmitter
//   tx_bit       offered bit value, held until accepted
//   tx_ready     transmitter accepts
//   line_rst     high for the whole latch gap
//   frame_done   one-cycle pulse on the last gap cycle
//   pixel_count  pixels sent since the last gap, saturating
//   busy         controller not idle
module rgbw_tx_sched #(
  parameter int unsigned RESET_CLKS = 7680,
  parameter bit          EN_WHITE   = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [31:0]      fifo_data,
  output logic             tx_valid,
  output logic             tx_bit,
  input  logic             tx_ready,
  output logic             line_rst,
  output logic             frame_done,
  output logic [CNT_W-1:0] pixel_count,
  output logic             busy
);

  localparam int unsigned GAP_W = $clog2(RESET_CLKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      shreg;
  logic [4:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             word_valid;
  logic             word_srst;
  logic             transfer;
  logic             last_bit;
  logic             gap_end;
  logic [7:0]       col_g, col_r, col_b, col_w;
  logic [31:0]      pix_word;

  // Received bytes arrive LSB-first relative to colour significance.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  assign word_valid = fifo_data[31];
  assign word_srst  = fifo_data[30];
  assign transfer   = (state == S_SHIFT) && tx_ready;
  assign last_bit   = (bit_cnt == 5'd31);
  assign gap_end    = (gap_cnt == '0);

  // Pixel decode and white extraction
  always_comb begin
    col_g = rev8(fifo_data[7:0]);
    col_r = rev8(fifo_data[15:8]);
    col_b = rev8(fifo_data[23:16]);
    col_w = '0;
    if (EN_WHITE) begin
      col_w = col_g;
      if (col_r < col_w) col_w = col_r;
      if (col_b < col_w) col_w = col_b;
    end
    pix_word = {col_g - col_w, col_r - col_w, col_b - col_w, col_w};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (!fifo_empty) state_nx = S_READ;
      S_READ: begin
        if (!word_valid)    state_nx = S_IDLE;
        else if (word_srst) state_nx = S_GAP;
        else                state_nx = S_SHIFT;
      end
      S_SHIFT: if (transfer && last_bit) state_nx = S_IDLE;
      S_GAP:   if (gap_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs. fifo_rd is gated by rst so the FIFO is never popped while the
  // controller is held in reset.
  always_comb begin
    fifo_rd    = (state == S_IDLE) && !fifo_empty && !rst;
    tx_valid   = (state == S_SHIFT);
    tx_bit     = (state == S_SHIFT) && shreg[31];
    line_rst   = (state == S_GAP);
    frame_done = (state == S_GAP) && gap_end;
    busy       = (state != S_IDLE);
  end

  // Datapath: shift register, bit/gap counters, pixel count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      pixel_count <= '0;
    end else begin
      unique case (state)
        S_READ: begin
          if (word_valid && word_srst) begin
            gap_cnt <= GAP_W'(RESET_CLKS - 1);
          end else if (word_valid) begin
            shreg   <= pix_word;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (transfer) begin
            shreg   <= {shreg[30:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (last_bit && (pixel_count != '1)) begin
              pixel_count <= pixel_count + CNT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_end) begin
            pixel_count <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_tx_sched.sv
// Testbench for rgbw_tx_sched. Two instances share clock, reset and tx_ready:
// index 0 extracts white with a 2-bit pixel counter, index 1 passes GRB
// through with a 16-bit counter. Each has its own FIFO model and scoreboard.
module tb_rgbw_tx_sched;

  localparam int RC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ready = 1'b1;
  logic [1:0]  fifo_empty = 2'b11;
  logic [1:0]  fifo_rd, tx_valid, tx_bit, line_rst, frame_done, busy;
  logic [31:0] fdat0 = '0, fdat1 = '0;
  logic [1:0]  pc_w;
  logic [15:0] pc_p;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int gaps_sent = 0;
  int gaps_seen [2];

  logic [31:0] fq0 [$];
  logic [31:0] fq1 [$];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic [1:0]  rd_seen = 2'b00;

  // Monitor state
  int          nb [2];
  logic [31:0] acc [2];
  logic [15:0] cnt_m [2];
  logic        prev_hold [2];
  logic        prev_bit [2];
  int          lr_run [2];
  int          fd_run [2];
  int          lat_cd [2];

  always #5 clk = ~clk;

  rgbw_tx_sched #(.RESET_CLKS(RC), .EN_WHITE(1'b1), .CNT_W(2)) u_dut_w (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_rd(fifo_rd[0]),
    .fifo_data(fdat0), .tx_valid(tx_valid[0]), .tx_bit(tx_bit[0]),
    .tx_ready(tx_ready), .line_rst(line_rst[0]), .frame_done(frame_done[0]),
    .pixel_count(pc_w), .busy(busy[0])
  );

  rgbw_tx_sched #(.RESET_CLKS(RC), .EN_WHITE(1'b0), .CNT_W(16)) u_dut_p (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_rd(fifo_rd[1]),
    .fifo_data(fdat1), .tx_valid(tx_valid[1]), .tx_bit(tx_bit[1]),
    .tx_ready(tx_ready), .line_rst(line_rst[1]), .frame_done(frame_done[1]),
    .pixel_count(pc_p), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel: colour values from received bits (bit 8n = MSB of byte n)
  function automatic logic [31:0] ref_px(input logic [31:0] w, input bit white);
    int c [3];
    int m;
    for (int n = 0; n < 3; n++) begin
      c[n] = 0;
      for (int k = 0; k < 8; k++) begin
        if (w[8*n+k]) c[n] += 1 << (7 - k);
      end
    end
    m = 0;
    if (white) begin
      m = c[0];
      if (c[1] < m) m = c[1];
      if (c[2] < m) m = c[2];
    end
    return {8'(c[0] - m), 8'(c[1] - m), 8'(c[2] - m), 8'(m)};
  endfunction

  // FIFO models: pop on the edge following a pop request, data valid next cycle
  always @(posedge clk) begin
    if (rd_seen[0]) begin
      if (fq0.size() == 0) chk("pop_empty_w", 32'd1, 32'd0);
      else fdat0 <= fq0.pop_front();
    end
    if (rd_seen[1]) begin
      if (fq1.size() == 0) chk("pop_empty_p", 32'd1, 32'd0);
      else fdat1 <= fq1.pop_front();
    end
    #2;
    fifo_empty[0] = (fq0.size() == 0);
    fifo_empty[1] = (fq1.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    tx_ready = (ready_mode != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    for (int d = 0; d < 2; d++) begin
      nb[d] = 0; acc[d] = '0; cnt_m[d] = '0; prev_hold[d] = 1'b0;
      prev_bit[d] = 1'b0; lr_run[d] = 0; fd_run[d] = 0; lat_cd[d] = 0;
      gaps_seen[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [15:0] pc;
      logic [15:0] maxc;
      logic [31:0] front;
      logic [31:0] expv;
      pc   = (d == 0) ? {14'b0, pc_w} : pc_p;
      maxc = (d == 0) ? 16'd3 : 16'hFFFF;
      if (rst) begin
        chk($sformatf("rst_outs%0d", d),
            {26'b0, fifo_rd[d], tx_valid[d], tx_bit[d], line_rst[d], frame_done[d], busy[d]}, '0);
        chk($sformatf("rst_count%0d", d), {16'b0, pc}, '0);
        if (nb[d] > 0) begin
          if (d == 0) void'(exp0.pop_front());
          else        void'(exp1.pop_front());
        end
        nb[d] = 0; acc[d] = '0; cnt_m[d] = '0; prev_hold[d] = 1'b0;
        lr_run[d] = 0; fd_run[d] = 0; lat_cd[d] = 0;
      end else begin
        chk($sformatf("pixel_count%0d", d), {16'b0, pc}, {16'b0, cnt_m[d]});
        if (prev_hold[d]) begin
          chk($sformatf("hold_valid%0d", d), {31'b0, tx_valid[d]}, 32'd1);
          chk($sformatf("hold_bit%0d", d), {31'b0, tx_bit[d]}, {31'b0, prev_bit[d]});
        end
        if (line_rst[d]) chk($sformatf("valid_in_gap%0d", d), {31'b0, tx_valid[d]}, 32'd0);
        if (fifo_rd[d])  chk($sformatf("rd_when_busy%0d", d), {31'b0, busy[d]}, 32'd0);
        if (frame_done[d]) chk($sformatf("fd_outside_gap%0d", d), {31'b0, line_rst[d]}, 32'd1);
        if (lat_cd[d] > 0) begin
          lat_cd[d]--;
          chk($sformatf("latency_valid%0d", d), {31'b0, tx_valid[d]}, (lat_cd[d] == 0) ? 32'd1 : 32'd0);
        end
        if (fifo_rd[d]) begin
          if (d == 0) front = (fq0.size() > 0) ? fq0[0] : 32'h0;
          else        front = (fq1.size() > 0) ? fq1[0] : 32'h0;
          if (front[31] && !front[30]) lat_cd[d] = 2;
        end
        if (tx_valid[d] && tx_ready) begin
          acc[d] = {acc[d][30:0], tx_bit[d]};
          nb[d]++;
          if (nb[d] == 32) begin
            if (d == 0 && exp0.size() > 0)      expv = exp0.pop_front();
            else if (d == 1 && exp1.size() > 0) expv = exp1.pop_front();
            else                                expv = ~acc[d];
            chk($sformatf("pixel%0d", d), acc[d], expv);
            nb[d] = 0;
            if (cnt_m[d] != maxc) cnt_m[d] = cnt_m[d] + 16'd1;
          end
        end
        prev_hold[d] = tx_valid[d] && !tx_ready;
        prev_bit[d]  = tx_bit[d];
        if (line_rst[d]) begin
          lr_run[d]++;
          if (frame_done[d]) begin
            fd_run[d]++;
            chk($sformatf("fd_position%0d", d), lr_run[d], RC);
            cnt_m[d] = '0;
          end
        end else if (lr_run[d] > 0) begin
          chk($sformatf("gap_len%0d", d), lr_run[d], RC);
          chk($sformatf("fd_pulses%0d", d), fd_run[d], 32'd1);
          gaps_seen[d]++;
          lr_run[d] = 0;
          fd_run[d] = 0;
        end
      end
    end
    rd_seen = rst ? 2'b00 : fifo_rd;
  end

  task automatic push(input logic [31:0] w);
    @(posedge clk);
    #1;
    fq0.push_back(w);
    fq1.push_back(w);
    if (w[31] && !w[30]) begin
      exp0.push_back(ref_px(w, 1'b1));
      exp1.push_back(ref_px(w, 1'b0));
    end else if (w[31] && w[30]) begin
      gaps_sent++;
    end
  endtask

  task automatic push_rand_px();
    logic [31:0] w;
    w = $urandom;
    w[31] = 1'b1;
    w[30] = 1'b0;
    push(w);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (fq0.size() == 0 && fq1.size() == 0 && busy == 2'b00 && fifo_rd == 2'b00 &&
          rd_seen == 2'b00)
        done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pure red and white extraction, tx_ready held high
    ready_mode = 0;
    push(32'h8000FF00);
    wait_idle(200);
    push(32'h80030102);
    wait_idle(200);

    // Backpressure
    ready_mode = 1;
    for (int i = 0; i < 6; i++) push_rand_px();
    wait_idle(3000);

    // Latch gap: clear, then 3 pixels, a discarded word, and a gap
    ready_mode = 0;
    push(32'hC0000000);
    wait_idle(200);
    for (int i = 0; i < 3; i++) push_rand_px();
    push(32'h00ABCDEF);
    wait_idle(400);
    chk("count_before_gap_p", {16'b0, pc_p}, 32'd3);
    chk("count_before_gap_w", {30'b0, pc_w}, 32'd3);
    push(32'hC0000000);
    wait_idle(200);
    chk("count_after_gap_p", {16'b0, pc_p}, 32'd0);

    // Back-to-back stream resets (data bits ignored)
    push(32'hC0FFFFFF);
    push(32'hC0000000);
    wait_idle(200);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) push_rand_px();
    wait_idle(600);
    chk("count_sat_w", {30'b0, pc_w}, 32'd3);
    chk("count_nosat_p", {16'b0, pc_p}, 32'd5);
    push(32'hC0000000);
    wait_idle(200);

    // Reset mid-pixel, then a clean pixel
    ready_mode = 1;
    push_rand_px();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk);
        if (nb[0] >= 9 && tx_valid[0]) hit = 1'b1;
      end
      if (!hit) chk("midpixel_timeout", 32'd1, 32'd0);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_outs", {24'b0, tx_valid, line_rst, busy, frame_done}, '0);
    chk("async_rst_bits", {28'b0, tx_bit, fifo_rd}, '0);
    chk("async_rst_count", {14'b0, pc_w, pc_p}, '0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    push(32'h80030102);
    push_rand_px();
    wait_idle(400);

    chk("scoreboard_empty_w", exp0.size(), 32'd0);
    chk("scoreboard_empty_p", exp1.size(), 32'd0);
    chk("gaps_w", gaps_seen[0], gaps_sent);
    chk("gaps_p", gaps_seen[1], gaps_sent);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rgbw_tx_sched.md
# rgbw_tx_sched

Output-side controller for the RGB→RGBW path. Pops 32-bit pixel/status words from the input FIFO, written by the serial-bit capture stage, and converts each GRB pixel to GRBW (white extraction). It then feeds the 32 resulting bits, MSB first, to the downstream WS2812/SK6812 bit transmitter over a valid/ready handshake. On a stream-reset word it drives the output latch gap, and it keeps a per-frame pixel count.

## Interface
- `RESET_CLKS`, default 7680: latch-gap length in clocks (80 µs at 96 MHz); must be ≥ 2.
- `EN_WHITE`, default 1: 1 = extract white; 0 = pass GRB through with W = 0.
- `CNT_W`, default 16: width of `pixel_count`.

Ports:
- `clk`  in  1  system clock, 96 MHz
- `rst`  in  1  reset; asynchronous, active-high
- `fifo_empty`  in  1  input FIFO empty
- `fifo_rd`  out  1  one-cycle pop pulse; `fifo_data` is valid exactly one cycle later
- `fifo_data`  in  32  input word format:
  - [31] valid
  - [30] stream_reset
  - [23:0] data, with bit k = k-th received bit
  - byte n = bits 8n..8n+7, with bit 8n as that byte's MSB
  - byte order G, R, B
- `tx_valid`  out  1  bit offered to transmitter
- `tx_bit`  out  1  bit value; stable while `tx_valid` and not accepted
- `tx_ready`  in  1  transmitter accepts; a transfer occurs when `tx_valid && tx_ready` at a clk edge
- `line_rst`  out  1  high for the whole latch gap
- `frame_done`  out  1  one-cycle pulse at end of latch gap
- `pixel_count`  out  `CNT_W`  pixels sent since last latch gap; saturates at all-ones
- `busy`  out  1  high in every state except IDLE

## Operation
States: IDLE, READ, SHIFT, GAP.

- **IDLE:**
  - If `!fifo_empty`: assert `fifo_rd` for one cycle and go to READ.
  - Otherwise stay.
- **READ:** sample `fifo_data` this cycle.
  - [31]=0: discard the word and go to IDLE.
  - [31]=1, [30]=1: ignore the data bits, load the gap counter with `RESET_CLKS-1`, go to GAP.
  - [31]=1, [30]=0: decode and load the shift register.
    - G = bit-reverse(data[7:0]), R = bit-reverse(data[15:8]), B = bit-reverse(data[23:16]).
    - If `EN_WHITE`: W = min(G,R,B); G' = G−W, R' = R−W, B' = B−W. All 8-bit unsigned; subtraction cannot underflow.
    - Otherwise: G' = G, R' = R, B' = B, W = 0.
    - Shift register = {G', R', B', W}. Clear the bit counter and go to SHIFT.
- **SHIFT:**
  - `tx_valid` = 1 and `tx_bit` = shreg[31].
  - On each transfer: shift left by 1 and increment the bit counter.
  - On the 32nd transfer: `pixel_count` += 1 (saturating), go to IDLE.
  - `tx_ready` low: hold; no timeout.
- **GAP:**
  - `line_rst` = 1 and `tx_valid` = 0. The counter decrements each clock.
  - When the counter reaches 0: pulse `frame_done` for one cycle, clear `pixel_count`, go to IDLE.
  - The FIFO is not popped during GAP.

Boundary rules:
- Consecutive stream-reset words each produce a full gap.
- Gaps are never merged or shortened.
- `fifo_empty` is ignored outside IDLE.
- A FIFO that empties mid-frame simply idles the controller; the line stays low via the transmitter.

## Timing
- Reset values (async, immediate): state IDLE; `fifo_rd`, `tx_valid`, `tx_bit`, `line_rst`, `frame_done`, `busy` = 0; `pixel_count` = 0.
- A reset asserted during SHIFT drops `tx_valid` immediately and loses the partial pixel. A reset during GAP ends the gap with no `frame_done`.
- Pop-to-first-bit latency: `fifo_rd` at cycle t, `fifo_data` sampled at t+1, `tx_valid` high at t+2.
- Pixel throughput with `tx_ready` held high: 32 transfers on cycles t+2..t+33. Earliest next `fifo_rd` is t+34, so the minimum pixel period is 34 clocks. The transmitter's bit time (1.25 µs) dominates in practice.
- GAP: `line_rst` is high for exactly `RESET_CLKS` cycles. `frame_done` occurs on the last of them. The earliest next `fifo_rd` is on the following cycle.
- `pixel_count` updates on the cycle after the 32nd transfer, and on the cycle after `frame_done`.

## Test plan
- **Pure red.** Received G=0x00, R=0xFF, B=0x00 gives `fifo_data` = 0x8000FF00. With `EN_WHITE`=1 and `tx_ready` held high, expect 32 bits = 0x00FF0000 MSB first. First `tx_valid` two cycles after `fifo_rd`; `pixel_count` = 1.
- **White extraction.** G=0x40, R=0x80, B=0xC0 gives `fifo_data` = 0x80_03_01_02 (bit-reversed bytes). Expect stream 0x00_40_80_40. Repeat with `EN_WHITE`=0 and expect 0x40_80_C0_00.
- **Backpressure.** Toggle `tx_ready` randomly 30% high. Expect `tx_bit` stable while unaccepted, exactly 32 transfers, and correct value.
- **Latch gap.** With `RESET_CLKS`=20, send 3 pixels, then word 0xC0000000. Expect `line_rst` high exactly 20 cycles, a single `frame_done`, and `pixel_count` going 3→0. A word with [31]=0 pops but produces no transfer.
- **Back-to-back resets and saturation.** Two stream-reset words produce two full gaps and two `frame_done` pulses. With `CNT_W`=2, 5 pixels hold `pixel_count` at 3.
- **Reset mid-operation.** Assert `rst` at the 10th bit of a pixel. Expect outputs at reset values within the same cycle, and the next popped pixel transmitted intact from bit 31.
